fp_mul_result_stage: RTL
========================

Name: fp_mul_result_stage

Overview:
- Registered output stage directly downstream of the combinational fp16 multiplier.
- Captures the 16-bit product and its class flags (sNaN, qNaN, infinity, zero, subnormal, normal) behind a valid/ready handshake, using a 2-entry skid buffer.
- Reduces the class flags to a one-hot class code.
- Accumulates sticky exception flags and a saturating result count for the FP CSR/writeback logic.

Parameters:
- COUNT_W, 16, width of the saturating result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  multiplier result valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_result  input  16  fp16 product {sign, exp[4:0], frac[9:0]}.
- in_snan, in_qnan, in_inf, in_zero, in_sub, in_norm  input  1 each  class flags from the multiplier.
- out_valid  output  1  out_result/out_class hold a valid entry.
- out_ready  input  1  consumer accepts the entry.
- out_result  output  16  registered product.
- out_class  output  6  one-hot class code {snan, qnan, inf, zero, sub, norm}.
- flag_nv  output  1  sticky invalid flag.
- flag_of  output  1  sticky overflow/infinity flag.
- flag_uf  output  1  sticky underflow/subnormal flag.
- flag_cls_err  output  1  sticky malformed-class flag.
- flags_clr  input  1  synchronous clear of sticky flags and counter.
- res_count  output  COUNT_W  saturating count of delivered results.

Behaviour:
- Reset (rst_n low, asynchronous) clears all state:
  - out_valid=0, out_result=0, out_class=0, skid entry invalid.
  - All sticky flags 0, res_count=0.
  - in_ready=0 while rst_n is low. in_ready=1 from the first cycle after release.
  - A reset asserted mid-transfer discards both entries; no partial output appears.
- in_ready = rst_n & ~skid_valid. It depends only on registered state, never on out_ready combinationally.
- Accept: in_valid & in_ready at the clock edge. Deliver: out_valid & out_ready at the clock edge.
- Storage: main register (drives out_*) and one skid register. On each edge:
  - Deliver with skid valid: skid moves to main and skid is freed. A same-edge accept is impossible here, because in_ready=0.
  - Accept when main is empty or is delivering (without skid): input loads main.
  - Accept when main is full and not delivering: input loads skid.
  - Deliver with no accept and skid empty: out_valid goes to 0.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 result/cycle while out_ready stays high.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- out_result and out_class hold stable while out_valid=1 and out_ready=0.
- Class reduction happens at accept time, with priority snan > qnan > inf > zero > sub > norm.
  - If multiple flags are set, only the highest-priority bit is kept.
  - If no flag is set, the class code is 6'b0 and flag_cls_err is set.
- Sticky flags update on accept, not on deliver, using the reduced class:
  - sNaN sets flag_nv.
  - inf sets flag_of.
  - sub sets flag_uf.
  - qNaN and zero set no flag.
- flags_clr clears flags and count in the same edge. Events on that same edge are applied after the clear:
  - accepted flags survive the clear;
  - res_count becomes 1 if a deliver occurs that edge, else 0.
- res_count increments on each deliver and saturates at all-ones (no wrap).

Test Plan:
- Reset, then accept 0x3C00 with in_norm=1 and out_ready=1 -> next cycle out_valid=1, out_result=0x3C00, out_class=6'b000001; the following cycle out_valid=0 and res_count=1.
- out_ready=0, then push 0x4000 and 0x4200 on consecutive cycles -> after the second accept in_ready=0 and out_result=0x4000. Raise out_ready -> 0x4000 and 0x4200 are delivered in order and in_ready returns to 1 the cycle after the first deliver.
- Accept 0x7D00 with in_snan=in_qnan=1 -> out_class=6'b100000 and flag_nv=1. Accept 0x7C00 with in_inf=1 -> flag_of=1, with flag_nv still 1.
- Accept with all class flags 0 -> out_class=0 and flag_cls_err=1. Assert flags_clr on the same edge as accepting a subnormal -> flag_uf=1 and the other flags 0.
- COUNT_W=2 with 5 back-to-back deliveries -> res_count is 1, 2, 3, 3, 3.
- Assert rst_n=0 with both entries full -> out_valid=0, in_ready=0, and all flags 0 immediately (no clock edge needed). After release, in_ready=1 and nothing is delivered.

Source files
------------

// File: rtl/fp_mul_result_stage_if.sv
// Handshake bundle between the fp16 multiplier, the result stage and its consumer.
// The stage takes the slave side; the producer/consumer environment takes the master side.
interface fp_mul_result_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_snan;
   logic        in_qnan;
   logic        in_inf;
   logic        in_zero;
   logic        in_sub;
   logic        in_norm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [5:0]  out_class;

   modport slave (
      input  in_valid, in_result, in_snan, in_qnan, in_inf, in_zero, in_sub, in_norm,
      input  out_ready,
      output in_ready, out_valid, out_result, out_class
   );

   modport master (
      output in_valid, in_result, in_snan, in_qnan, in_inf, in_zero, in_sub, in_norm,
      output out_ready,
      input  in_ready, out_valid, out_result, out_class
   );
endinterface

// File: rtl/fp_mul_result_stage.sv
// Registered output stage for the fp16 multiplier: 2-entry skid buffer, one-hot class
// reduction, sticky exception flags and a saturating delivered-result counter.
module fp_mul_result_stage #(
   parameter int COUNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fp_mul_result_stage_if.slave       bus,
   input  logic                       flags_clr,
   output logic                       flag_nv,
   output logic                       flag_of,
   output logic                       flag_uf,
   output logic                       flag_cls_err,
   output logic [COUNT_W-1:0]         res_count
);

   logic [5:0]          in_flags;
   logic [5:0]          in_class;
   logic                accept;
   logic                deliver;

   logic                main_valid_q;
   logic [15:0]         main_result_q;
   logic [5:0]          main_class_q;
   logic                skid_valid_q;
   logic [15:0]         skid_result_q;
   logic [5:0]          skid_class_q;

   logic                flag_nv_q, flag_nv_d;
   logic                flag_of_q, flag_of_d;
   logic                flag_uf_q, flag_uf_d;
   logic                flag_err_q, flag_err_d;
   logic [COUNT_W-1:0]  count_q, count_d;

   assign in_flags = {bus.in_snan, bus.in_qnan, bus.in_inf, bus.in_zero, bus.in_sub, bus.in_norm};

   // Keep a flag only if no higher-priority flag (higher bit) is also set.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_pri
         if (gi == 5) begin : g_top
            assign in_class[gi] = in_flags[gi];
         end else begin : g_low
            assign in_class[gi] = in_flags[gi] & ~(|in_flags[5:gi+1]);
         end
      end
   endgenerate

   assign bus.in_ready   = rst_n & ~skid_valid_q;
   assign accept         = bus.in_valid & bus.in_ready;
   assign deliver        = main_valid_q & bus.out_ready;

   assign bus.out_valid  = main_valid_q;
   assign bus.out_result = main_result_q;
   assign bus.out_class  = main_class_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q  <= 1'b0;
         main_result_q <= '0;
         main_class_q  <= '0;
         skid_valid_q  <= 1'b0;
         skid_result_q <= '0;
         skid_class_q  <= '0;
      end else begin
         if (deliver && skid_valid_q) begin
            main_result_q <= skid_result_q;
            main_class_q  <= skid_class_q;
            skid_valid_q  <= 1'b0;
         end else if (accept && (!main_valid_q || deliver)) begin
            main_valid_q  <= 1'b1;
            main_result_q <= bus.in_result;
            main_class_q  <= in_class;
         end else if (accept) begin
            skid_valid_q  <= 1'b1;
            skid_result_q <= bus.in_result;
            skid_class_q  <= in_class;
         end else if (deliver) begin
            main_valid_q  <= 1'b0;
         end
      end
   end

   // Clear first, then fold in this edge's events so they survive a same-edge clear.
   always_comb begin
      flag_nv_d  = flag_nv_q  & ~flags_clr;
      flag_of_d  = flag_of_q  & ~flags_clr;
      flag_uf_d  = flag_uf_q  & ~flags_clr;
      flag_err_d = flag_err_q & ~flags_clr;
      count_d    = flags_clr ? '0 : count_q;
      if (accept) begin
         flag_nv_d  = flag_nv_d  | in_class[5];
         flag_of_d  = flag_of_d  | in_class[3];
         flag_uf_d  = flag_uf_d  | in_class[1];
         flag_err_d = flag_err_d | (in_class == 6'b0);
      end
      if (deliver && (count_d != {COUNT_W{1'b1}})) begin
         count_d = count_d + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_nv_q  <= 1'b0;
         flag_of_q  <= 1'b0;
         flag_uf_q  <= 1'b0;
         flag_err_q <= 1'b0;
         count_q    <= '0;
      end else begin
         flag_nv_q  <= flag_nv_d;
         flag_of_q  <= flag_of_d;
         flag_uf_q  <= flag_uf_d;
         flag_err_q <= flag_err_d;
         count_q    <= count_d;
      end
   end

   assign flag_nv      = flag_nv_q;
   assign flag_of      = flag_of_q;
   assign flag_uf      = flag_uf_q;
   assign flag_cls_err = flag_err_q;
   assign res_count    = count_q;

endmodule
